// File: rtl/seg7_msg_sequencer_if.sv
// Control and display bus of the seven-segment message sequencer.
// Controls are driven by the master; the sequencer (slave) returns the registered display state.
interface seg7_msg_sequencer_if #(
    parameter int IDX_W = 4
);
    logic [1:0]       mode;
    logic [2:0]       rate_sel;
    logic             pause;
    logic             step;
    logic             start;
    logic [7:0]       seg;
    logic [IDX_W-1:0] index;
    logic             done;
    logic             wrap;

    modport master (
        output mode, rate_sel, pause, step, start,
        input  seg, index, done, wrap
    );

    modport slave (
        input  mode, rate_sel, pause, step, start,
        output seg, index, done, wrap
    );
endinterface

// File: rtl/seg7_msg_sequencer.sv
// Steps a fixed seven-segment pattern table in scroll/bounce/one-shot/hold modes.
// Latency: one edge from any control input to seg/index/done/wrap.
// No backpressure: the display consumes every pattern; pause/step gate the stepping.
module seg7_msg_sequencer #(
    parameter int                   MSG_LEN    = 15,
    parameter logic [MSG_LEN*8-1:0] MSG        = {8'h0E, 8'h3E, 8'h15, 8'h7E, 8'h5F,
                                                  8'h0E, 8'h3E, 8'h5F, 8'h0E, 8'h7E,
                                                  8'h15, 8'h4F, 8'h5B, 8'h80, 8'h00},
    parameter int                   BASE_SHIFT = 0,
    parameter int                   DIV_W      = 24,
    localparam int                  IDX_W      = $clog2(MSG_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_msg_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_SCROLL  = 2'd0,
        MODE_BOUNCE  = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_t;

    localparam int               SH_W = $clog2(DIV_W + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(MSG_LEN - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    mode_t            mode;
    logic [SH_W-1:0]  shamt;
    logic [DIV_W-1:0] pre_lim;
    logic [DIV_W-1:0] pre_q, pre_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic             dir_q, dir_nxt;
    logic             done_q, done_nxt;
    logic             wrap_q, wrap_nxt;
    logic [7:0]       seg_q, seg_nxt;
    logic             tick;
    logic             adv;

    assign mode    = mode_t'(bus.mode);
    assign shamt   = SH_W'(BASE_SHIFT) + SH_W'(bus.rate_sel);
    assign pre_lim = (DIV_W'(1) << shamt) - DIV_W'(1);

    // A >= compare so a shrinking period fires immediately rather than wrapping the counter.
    assign tick = !bus.pause && (pre_q >= pre_lim);
    assign adv  = (tick || (bus.pause && bus.step)) && (mode != MODE_HOLD);

    always_comb begin
        pre_nxt = pre_q;
        if (bus.start || tick) begin
            pre_nxt = '0;
        end else if (!bus.pause) begin
            pre_nxt = pre_q + DIV_W'(1);
        end
    end

    always_comb begin
        idx_nxt  = idx_q;
        dir_nxt  = (mode == MODE_BOUNCE) ? dir_q : 1'b1;
        done_nxt = (mode == MODE_ONESHOT) ? done_q : 1'b0;
        wrap_nxt = 1'b0;
        if (bus.start) begin
            idx_nxt  = '0;
            dir_nxt  = 1'b1;
            done_nxt = 1'b0;
        end else if (adv) begin
            unique case (mode)
                MODE_SCROLL: begin
                    if (idx_q == LAST) begin
                        idx_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx_q + ONE;
                    end
                end
                MODE_BOUNCE: begin
                    // Endpoints turn around immediately so each end is shown once per pass.
                    if (dir_q) begin
                        if (idx_q == LAST) begin
                            dir_nxt = 1'b0;
                            idx_nxt = LAST - ONE;
                        end else begin
                            idx_nxt = idx_q + ONE;
                        end
                    end else begin
                        if (idx_q == '0) begin
                            dir_nxt = 1'b1;
                            idx_nxt = ONE;
                        end else begin
                            idx_nxt = idx_q - ONE;
                        end
                    end
                    wrap_nxt = (idx_q == ONE) && (idx_nxt == '0);
                end
                MODE_ONESHOT: begin
                    if (idx_q == LAST) begin
                        done_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx_q + ONE;
                    end
                end
                default: begin
                    idx_nxt = idx_q;
                end
            endcase
        end
    end

    assign seg_nxt = MSG[{idx_nxt, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            idx_q  <= '0;
            dir_q  <= 1'b1;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            seg_q  <= 8'h00;
        end else begin
            pre_q  <= pre_nxt;
            idx_q  <= idx_nxt;
            dir_q  <= dir_nxt;
            done_q <= done_nxt;
            wrap_q <= wrap_nxt;
            seg_q  <= seg_nxt;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.index = idx_q;
    assign bus.done  = done_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_seg7_msg_sequencer.sv
// Randomised and directed stimulus for seg7_msg_sequencer, checked against a behavioural model
// that tracks the message position, bounce phase and prescaler count as plain integers.
module tb_seg7_msg_sequencer;
    localparam int L = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg7_msg_sequencer_if #(.IDX_W(4)) bus();

    seg7_msg_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int msg_tab [L] = '{8'h00, 8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F,
                        8'h3E, 8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E};

    int m_idx, m_pre, m_seg;
    bit m_up, m_done, m_wrap;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idx  = 0;
        m_pre  = 0;
        m_up   = 1'b1;
        m_done = 1'b0;
        m_wrap = 1'b0;
        m_seg  = 0;
    endtask

    // Bounce is modelled as a position on a zig-zag of length 2L-2 rather than index+direction.
    task automatic model_edge();
        int  period, ph;
        bit  t, a;
        period = 1 << int'(bus.rate_sel);
        t      = !bus.pause && (m_pre >= period - 1);
        a      = (t || (bus.pause && bus.step)) && (bus.mode != 2'd3);
        if (bus.start || t) m_pre = 0;
        else if (!bus.pause) m_pre++;
        m_wrap = 1'b0;
        if (bus.mode != 2'd1) m_up = 1'b1;
        if (bus.mode != 2'd2) m_done = 1'b0;
        if (bus.start) begin
            m_idx  = 0;
            m_up   = 1'b1;
            m_done = 1'b0;
        end else if (a) begin
            case (bus.mode)
                2'd0: begin
                    m_idx  = (m_idx + 1) % L;
                    m_wrap = (m_idx == 0);
                end
                2'd1: begin
                    ph     = m_up ? m_idx : (2*L - 2 - m_idx);
                    ph     = (ph + 1) % (2*L - 2);
                    m_idx  = (ph < L) ? ph : (2*L - 2 - ph);
                    m_up   = (ph < L - 1);
                    m_wrap = (m_idx == 0);
                end
                2'd2: begin
                    if (m_idx == L - 1) m_done = 1'b1;
                    else m_idx++;
                end
                default: ;
            endcase
        end
        m_seg = msg_tab[m_idx];
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".index"}, int'(bus.index), m_idx);
        check({tag, ".seg"},   int'(bus.seg),   m_seg);
        check({tag, ".wrap"},  int'(bus.wrap),  int'(m_wrap));
        check({tag, ".done"},  int'(bus.done),  int'(m_done));
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input int md, input int rs, input bit ps, input bit st, input bit sr);
        bus.mode     = 2'(md);
        bus.rate_sel = 3'(rs);
        bus.pause    = ps;
        bus.step     = st;
        bus.start    = sr;
    endtask

    initial begin
        int prev;
        int md;
        int rs;
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        #2;
        model_reset();
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        repeat (40) cycle("scroll");

        drive(0, 2, 1'b0, 1'b0, 1'b0);
        repeat (24) cycle("rate2");
        drive(0, 7, 1'b0, 1'b0, 1'b0);
        repeat (10) cycle("rate7");
        prev = m_idx;
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        cycle("rate_shrink");
        check("rate_shrink.adv", int'(bus.index), (prev + 1) % L);

        drive(1, 0, 1'b0, 1'b0, 1'b1);
        cycle("bounce_start");
        drive(1, 0, 1'b0, 1'b0, 1'b0);
        repeat (64) cycle("bounce");

        drive(2, 0, 1'b0, 1'b0, 1'b1);
        cycle("oneshot_start");
        drive(2, 0, 1'b0, 1'b0, 1'b0);
        repeat (70) cycle("oneshot");
        check("oneshot.done_held", int'(bus.done), 1);
        drive(2, 0, 1'b0, 1'b0, 1'b1);
        cycle("oneshot_restart");
        check("oneshot_restart.index0", int'(bus.index), 0);

        drive(0, 0, 1'b1, 1'b0, 1'b0);
        repeat (20) cycle("pause");
        prev = m_idx;
        drive(0, 0, 1'b1, 1'b1, 1'b0);
        repeat (3) cycle("step");
        check("step.plus3", int'(bus.index), (prev + 3) % L);
        drive(3, 0, 1'b1, 1'b1, 1'b0);
        repeat (3) cycle("hold_step");
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        cycle("start_vs_adv");

        md = 0;
        rs = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) md = int'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) rs = ($urandom_range(0, 7) == 0) ? 7 : int'($urandom_range(0, 3));
            drive(md, rs, ($urandom_range(0, 3) == 0), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 59) == 0);
            cycle("random");
        end

        drive(0, 0, 1'b0, 1'b0, 1'b1);
        cycle("pre_arst");
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40 && m_idx != 9; i++) cycle("to_idx9");
        check("arst.reached_idx9", int'(bus.index), 9);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) cycle("after_arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
